// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART controller.
//   - parity mode constants used by the PARITY parameter
//   - state encodings of the TX and RX engines
//   - 16x oversampling ratio of the baud tick
//   - parity helper shared by the TX and RX engines
package uart_pkg;

    localparam int unsigned PAR_NONE   = 0;
    localparam int unsigned PAR_ODD    = 1;
    localparam int unsigned PAR_EVEN   = 2;

    localparam int unsigned OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

    // Expected parity bit for a word that is zero-extended to 8 bits.
    // Zero padding does not disturb the XOR, so any DATA_BITS from 5 to 8 fits.
    function automatic logic calc_parity(input logic [7:0] data, input int unsigned mode);
        return (^data) ^ (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
//   clk, rst   : clock, asynchronous active-low reset
//   push, din  : write request and data (ignored when full unless popping)
//   pop        : consume the head (ignored when empty)
//   dout       : head of the queue, forced to zero while empty
//   full/empty : registered-level derived status
//   level      : registered occupancy, 0..DEPTH
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is accepted only when the head leaves on the same edge.
    assign do_pop  = pop && (level_q != '0);
    assign do_push = push && ((level_q != LW'(DEPTH)) || do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);
    assign dout  = empty ? '0 : mem_q[rd_ptr_q];
    assign level = level_q;

endmodule

// File: rtl/uart_core_param.sv
// Parametrised UART controller: baud tick generator, TX and RX engines,
// one FIFO per direction, configurable frame format and echo mode.
//   clk, rst          : clock, asynchronous active-low reset
//   rx / tx           : serial pins (tx idles high)
//   tx_push, tx_data  : queue a word for transmission (ignored in echo mode)
//   tx_full, tx_level : TX FIFO status
//   tx_busy, tx_done  : frame in progress / pulse at end of last stop bit
//   rx_pop, rx_data   : consume / view the RX FIFO head
//   rx_empty, rx_level: RX FIFO status
//   rx_done           : pulse when a frame completes (good or bad)
//   echo_en           : copy every received word into the TX FIFO
//   err_clr           : clear the sticky error flags
//   rx_parity_err, rx_frame_err, rx_overrun : sticky error flags
module uart_core_param
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned BAUD       = 115_200,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx,
    output logic                          tx,
    input  logic                          tx_push,
    input  logic [DATA_BITS-1:0]          tx_data,
    output logic                          tx_full,
    output logic [$clog2(FIFO_DEPTH):0]   tx_level,
    output logic                          tx_busy,
    output logic                          tx_done,
    input  logic                          rx_pop,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_empty,
    output logic [$clog2(FIFO_DEPTH):0]   rx_level,
    output logic                          rx_done,
    input  logic                          echo_en,
    input  logic                          err_clr,
    output logic                          rx_parity_err,
    output logic                          rx_frame_err,
    output logic                          rx_overrun
);

    localparam int unsigned DIV   = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    // ---------------- tick generator ----------------
    logic [DIV_W-1:0] div_q;
    logic             tick;

    assign tick = (div_q == DIV_W'(DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q <= '0;
        end else if (tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

    // ---------------- FIFOs ----------------
    logic                 tx_fifo_push;
    logic                 tx_fifo_pop;
    logic [DATA_BITS-1:0] tx_fifo_din;
    logic [DATA_BITS-1:0] tx_fifo_dout;
    logic                 tx_fifo_empty;
    logic                 rx_fifo_push;
    logic                 rx_fifo_full;

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_fifo_push),
        .pop   (tx_fifo_pop),
        .din   (tx_fifo_din),
        .dout  (tx_fifo_dout),
        .full  (tx_full),
        .empty (tx_fifo_empty),
        .level (tx_level)
    );

    // ---------------- RX engine ----------------
    logic                 rx_meta_q, rx_sync_q;
    rx_state_e            rx_state_q, rx_state_d;
    logic [3:0]           rx_tcnt_q, rx_tcnt_d;
    logic [2:0]           rx_bcnt_q, rx_bcnt_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 rx_par_q, rx_par_d;
    logic                 rx_complete, rx_word_ok, rx_par_bad;
    logic                 set_par, set_frame, set_ovr, echo_push;
    logic                 rx_done_q, rx_parity_err_q, rx_frame_err_q, rx_overrun_q;

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_fifo_push),
        .pop   (rx_pop),
        .din   (rx_shift_q),
        .dout  (rx_data),
        .full  (rx_fifo_full),
        .empty (rx_empty),
        .level (rx_level)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q       <= 1'b1;
            rx_sync_q       <= 1'b1;
            rx_state_q      <= RX_IDLE;
            rx_tcnt_q       <= '0;
            rx_bcnt_q       <= '0;
            rx_shift_q      <= '0;
            rx_par_q        <= 1'b0;
            rx_done_q       <= 1'b0;
            rx_parity_err_q <= 1'b0;
            rx_frame_err_q  <= 1'b0;
            rx_overrun_q    <= 1'b0;
        end else begin
            rx_meta_q       <= rx;
            rx_sync_q       <= rx_meta_q;
            rx_state_q      <= rx_state_d;
            rx_tcnt_q       <= rx_tcnt_d;
            rx_bcnt_q       <= rx_bcnt_d;
            rx_shift_q      <= rx_shift_d;
            rx_par_q        <= rx_par_d;
            rx_done_q       <= rx_complete;
            // Set has priority over a simultaneous clear.
            rx_parity_err_q <= set_par   | (rx_parity_err_q & ~err_clr);
            rx_frame_err_q  <= set_frame | (rx_frame_err_q  & ~err_clr);
            rx_overrun_q    <= set_ovr   | (rx_overrun_q    & ~err_clr);
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_tcnt_d  = rx_tcnt_q;
        rx_bcnt_d  = rx_bcnt_q;
        rx_shift_d = rx_shift_q;
        rx_par_d   = rx_par_q;
        unique case (rx_state_q)
            RX_IDLE: begin
                if (!rx_sync_q) begin
                    rx_state_d = RX_START;
                    rx_tcnt_d  = '0;
                end
            end
            RX_START: begin
                if (tick) begin
                    if (rx_tcnt_q == 4'd7) begin
                        // Mid start bit: a high here was only a glitch.
                        rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                        rx_tcnt_d  = '0;
                        rx_bcnt_d  = '0;
                    end else begin
                        rx_tcnt_d = rx_tcnt_q + 4'd1;
                    end
                end
            end
            RX_DATA: begin
                if (tick) begin
                    rx_tcnt_d = rx_tcnt_q + 4'd1;
                    if (rx_tcnt_q == 4'd15) begin
                        rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
                        if (rx_bcnt_q == 3'(DATA_BITS - 1)) begin
                            rx_state_d = (PARITY != PAR_NONE) ? RX_PARITY : RX_STOP;
                        end else begin
                            rx_bcnt_d = rx_bcnt_q + 3'd1;
                        end
                    end
                end
            end
            RX_PARITY: begin
                if (tick) begin
                    rx_tcnt_d = rx_tcnt_q + 4'd1;
                    if (rx_tcnt_q == 4'd15) begin
                        rx_par_d   = rx_sync_q;
                        rx_state_d = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (tick) begin
                    rx_tcnt_d = rx_tcnt_q + 4'd1;
                    if (rx_tcnt_q == 4'd15) begin
                        rx_state_d = RX_IDLE;
                    end
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        rx_complete  = (rx_state_q == RX_STOP) && tick && (rx_tcnt_q == 4'd15);
        rx_word_ok   = rx_complete && rx_sync_q;
        rx_par_bad   = (PARITY != PAR_NONE) &&
                       (rx_par_q != calc_parity(8'(rx_shift_q), PARITY));
        // A full FIFO still takes the word if its head is popped on this edge.
        rx_fifo_push = rx_word_ok && (!rx_fifo_full || rx_pop);
        echo_push    = echo_en && rx_fifo_push;
        set_frame    = rx_complete && !rx_sync_q;
        set_par      = rx_word_ok && rx_par_bad;
        set_ovr      = rx_word_ok && rx_fifo_full && !rx_pop;
    end

    assign rx_done       = rx_done_q;
    assign rx_parity_err = rx_parity_err_q;
    assign rx_frame_err  = rx_frame_err_q;
    assign rx_overrun    = rx_overrun_q;

    // ---------------- TX engine ----------------
    tx_state_e            tx_state_q, tx_state_d;
    logic [3:0]           tx_tcnt_q, tx_tcnt_d;
    logic [2:0]           tx_bcnt_q, tx_bcnt_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_par_q, tx_par_d;
    logic                 tx_req_q;
    logic                 tx_q, tx_d, tx_busy_q, tx_busy_d, tx_done_q;
    logic                 tx_bit_end, tx_last;

    assign tx_fifo_push = echo_en ? echo_push : tx_push;
    assign tx_fifo_din  = echo_en ? rx_shift_q : tx_data;

    assign tx_bit_end = tick && (tx_tcnt_q == 4'd15);
    assign tx_last    = (tx_state_q == TX_STOP) && tx_bit_end &&
                        (tx_bcnt_q == 3'(STOP_BITS - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state_q <= TX_IDLE;
            tx_tcnt_q  <= '0;
            tx_bcnt_q  <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_req_q   <= 1'b0;
            tx_q       <= 1'b1;
            tx_busy_q  <= 1'b0;
            tx_done_q  <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_tcnt_q  <= tx_tcnt_d;
            tx_bcnt_q  <= tx_bcnt_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            tx_req_q   <= !tx_fifo_empty;
            tx_q       <= tx_d;
            tx_busy_q  <= tx_busy_d;
            tx_done_q  <= tx_last;
        end
    end

    // Idle start waits on the registered request so the FIFO status never sits on
    // the load path; a frame ending with data queued reloads straight into START.
    always_comb begin
        tx_state_d  = tx_state_q;
        tx_tcnt_d   = tx_tcnt_q;
        tx_bcnt_d   = tx_bcnt_q;
        tx_shift_d  = tx_shift_q;
        tx_par_d    = tx_par_q;
        tx_fifo_pop = 1'b0;
        if (tx_state_q != TX_IDLE && tick) begin
            tx_tcnt_d = tx_tcnt_q + 4'd1;
        end
        unique case (tx_state_q)
            TX_IDLE: begin
                if (tx_req_q && !tx_fifo_empty) begin
                    tx_fifo_pop = 1'b1;
                end
            end
            TX_START: begin
                if (tx_bit_end) begin
                    tx_state_d = TX_DATA;
                    tx_bcnt_d  = '0;
                end
            end
            TX_DATA: begin
                if (tx_bit_end) begin
                    tx_shift_d = tx_shift_q >> 1;
                    if (tx_bcnt_q == 3'(DATA_BITS - 1)) begin
                        tx_state_d = (PARITY != PAR_NONE) ? TX_PARITY : TX_STOP;
                        tx_bcnt_d  = '0;
                    end else begin
                        tx_bcnt_d = tx_bcnt_q + 3'd1;
                    end
                end
            end
            TX_PARITY: begin
                if (tx_bit_end) begin
                    tx_state_d = TX_STOP;
                    tx_bcnt_d  = '0;
                end
            end
            TX_STOP: begin
                if (tx_last) begin
                    tx_state_d  = TX_IDLE;
                    tx_fifo_pop = !tx_fifo_empty;
                end else if (tx_bit_end) begin
                    tx_bcnt_d = tx_bcnt_q + 3'd1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
        if (tx_fifo_pop) begin
            tx_state_d = TX_START;
            tx_tcnt_d  = '0;
            tx_shift_d = tx_fifo_dout;
            tx_par_d   = calc_parity(8'(tx_fifo_dout), PARITY);
        end
    end

    // Line value is computed from the next state so the pin itself is a flop.
    always_comb begin
        unique case (tx_state_d)
            TX_START:  tx_d = 1'b0;
            TX_DATA:   tx_d = tx_shift_d[0];
            TX_PARITY: tx_d = tx_par_d;
            default:   tx_d = 1'b1;
        endcase
        tx_busy_d = (tx_state_d != TX_IDLE);
    end

    assign tx      = tx_q;
    assign tx_busy = tx_busy_q;
    assign tx_done = tx_done_q;

endmodule

// File: tb/tb_uart_core_param.sv
// Directed bench for uart_core_param.
// dut0: 8N1, 16-deep FIFOs, used for TX, framing, glitch, echo and reset cases.
// dut1: 8E1, 4-deep FIFOs, used for parity and overrun cases.
// Both run at 4 clocks per tick (64 clocks per bit) to keep frames short.
module tb_uart_core_param;

    localparam int unsigned CLK_HZ   = 7_372_800;
    localparam int unsigned BAUD     = 115_200;
    localparam int          BIT_CLKS = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic       rx0, tx0, tx_push0, tx_full0, tx_busy0, tx_done0;
    logic       rx_pop0, rx_empty0, rx_done0, echo_en0, err_clr0;
    logic       perr0, ferr0, ovr0;
    logic [7:0] tx_data0, rx_data0;
    logic [4:0] tx_level0, rx_level0;

    logic       rx1, tx1, tx_push1, tx_full1, tx_busy1, tx_done1;
    logic       rx_pop1, rx_empty1, rx_done1, echo_en1, err_clr1;
    logic       perr1, ferr1, ovr1;
    logic [7:0] tx_data1, rx_data1;
    logic [2:0] tx_level1, rx_level1;

    uart_core_param #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0),
        .STOP_BITS(1), .FIFO_DEPTH(16)
    ) u_dut0 (
        .clk(clk), .rst(rst), .rx(rx0), .tx(tx0),
        .tx_push(tx_push0), .tx_data(tx_data0), .tx_full(tx_full0),
        .tx_level(tx_level0), .tx_busy(tx_busy0), .tx_done(tx_done0),
        .rx_pop(rx_pop0), .rx_data(rx_data0), .rx_empty(rx_empty0),
        .rx_level(rx_level0), .rx_done(rx_done0), .echo_en(echo_en0),
        .err_clr(err_clr0), .rx_parity_err(perr0), .rx_frame_err(ferr0),
        .rx_overrun(ovr0)
    );

    uart_core_param #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(2),
        .STOP_BITS(1), .FIFO_DEPTH(4)
    ) u_dut1 (
        .clk(clk), .rst(rst), .rx(rx1), .tx(tx1),
        .tx_push(tx_push1), .tx_data(tx_data1), .tx_full(tx_full1),
        .tx_level(tx_level1), .tx_busy(tx_busy1), .tx_done(tx_done1),
        .rx_pop(rx_pop1), .rx_data(rx_data1), .rx_empty(rx_empty1),
        .rx_level(rx_level1), .rx_done(rx_done1), .echo_en(echo_en1),
        .err_clr(err_clr1), .rx_parity_err(perr1), .rx_frame_err(ferr1),
        .rx_overrun(ovr1)
    );

    int n_checks = 0;
    int n_errors = 0;

    int txd_cnt0 = 0;
    int rxd_cnt0 = 0;
    int rxd_cnt1 = 0;

    always @(posedge clk) begin
        if (tx_done0) txd_cnt0 <= txd_cnt0 + 1;
        if (rx_done0) rxd_cnt0 <= rxd_cnt0 + 1;
        if (rx_done1) rxd_cnt1 <= rxd_cnt1 + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_rx(input int sel, input logic v);
        if (sel == 0) rx0 = v;
        else          rx1 = v;
    endtask

    // Start, 8 data bits LSB first, optional even parity (optionally flipped), stop.
    // A low stop bit is held only briefly so the line does not look like a new frame.
    task automatic send_frame(input int sel, input logic [7:0] data, input bit with_par,
                              input bit par_flip, input logic stop_val);
        set_rx(sel, 1'b0);
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            set_rx(sel, data[i]);
            repeat (BIT_CLKS) @(negedge clk);
        end
        if (with_par) begin
            set_rx(sel, (^data) ^ par_flip);
            repeat (BIT_CLKS) @(negedge clk);
        end
        set_rx(sel, stop_val);
        repeat (stop_val ? BIT_CLKS : 48) @(negedge clk);
        set_rx(sel, 1'b1);
    endtask

    // Waits (bounded) for a start bit on tx0 and samples 10 bits at mid-bit.
    task automatic get_tx_frame(input int limit, output logic [9:0] bits,
                                output bit found, output int waited);
        waited = 0;
        bits   = '1;
        while (tx0 !== 1'b0 && waited < limit) begin
            @(negedge clk);
            waited++;
        end
        found = (tx0 === 1'b0);
        if (found) begin
            repeat (BIT_CLKS / 2) @(negedge clk);
            bits[0] = tx0;
            for (int k = 1; k < 10; k++) begin
                repeat (BIT_CLKS) @(negedge clk);
                bits[k] = tx0;
            end
        end
    endtask

    task automatic pop_rx(input int sel);
        @(negedge clk);
        if (sel == 0) rx_pop0 = 1'b1; else rx_pop1 = 1'b1;
        @(negedge clk);
        rx_pop0 = 1'b0;
        rx_pop1 = 1'b0;
    endtask

    logic [9:0] fr;
    bit         found;
    int         waited;

    initial begin
        rst = 1'b0;
        rx0 = 1'b1; tx_push0 = 1'b0; tx_data0 = '0; rx_pop0 = 1'b0; echo_en0 = 1'b0; err_clr0 = 1'b0;
        rx1 = 1'b1; tx_push1 = 1'b0; tx_data1 = '0; rx_pop1 = 1'b0; echo_en1 = 1'b0; err_clr1 = 1'b0;

        // ---- reset values ----
        repeat (5) @(negedge clk);
        check("rst_tx",       tx0, 1);
        check("rst_tx_busy",  tx_busy0, 0);
        check("rst_tx_done",  tx_done0, 0);
        check("rst_rx_done",  rx_done0, 0);
        check("rst_rx_empty", rx_empty0, 1);
        check("rst_tx_full",  tx_full0, 0);
        check("rst_tx_level", tx_level0, 0);
        check("rst_rx_level", rx_level0, 0);
        check("rst_rx_data",  rx_data0, 0);
        check("rst_errs",     {perr0, ferr0, ovr0}, 0);
        check("rst_dut1_tx",  {tx1, tx_busy1, tx_done1, tx_full1}, 4'b1000);
        check("rst_dut1_lvl", {tx_level1, rx_level1}, 0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // ---- TX back-to-back: 0xA5 then 0x3C ----
        tx_data0 = 8'hA5; tx_push0 = 1'b1;
        @(negedge clk);                       // after edge N
        check("txq_level_1", tx_level0, 1);
        tx_data0 = 8'h3C;
        @(negedge clk);                       // after edge N+1
        tx_push0 = 1'b0;
        check("txq_level_2", tx_level0, 2);
        check("tx_idle_n1",  {tx0, tx_busy0}, 2'b10);
        @(negedge clk);                       // after edge N+2
        check("tx_start_n2", {tx0, tx_busy0}, 2'b01);
        check("txq_level_3", tx_level0, 1);
        get_tx_frame(100, fr, found, waited);
        check("tx_frame1_seen", found, 1);
        check("tx_frame1",  fr, {1'b1, 8'hA5, 1'b0});
        get_tx_frame(100, fr, found, waited);
        check("tx_frame2_seen", found, 1);
        check("tx_b2b_gap", (waited <= 40), 1);
        check("tx_frame2",  fr, {1'b1, 8'h3C, 1'b0});
        check("txq_level_0", tx_level0, 0);
        repeat (64) @(negedge clk);
        check("tx_done_cnt", txd_cnt0, 2);
        check("tx_end_idle", {tx0, tx_busy0}, 2'b10);

        // ---- RX even parity on dut1 ----
        send_frame(1, 8'h55, 1'b1, 1'b0, 1'b1);
        check("par_ok_done",  rxd_cnt1, 1);
        check("par_ok_data",  rx_data1, 8'h55);
        check("par_ok_state", {rx_empty1, perr1, ferr1, ovr1}, 0);
        check("par_ok_level", rx_level1, 1);
        pop_rx(1);
        check("par_ok_popped", rx_empty1, 1);
        send_frame(1, 8'h55, 1'b1, 1'b1, 1'b1);
        check("par_bad_data", rx_data1, 8'h55);
        check("par_bad_flag", perr1, 1);
        repeat (100) @(negedge clk);
        check("par_bad_sticky", perr1, 1);
        err_clr1 = 1'b1; @(negedge clk); err_clr1 = 1'b0;
        check("par_clr", perr1, 0);
        pop_rx(1);

        // ---- framing error and glitch on dut0 ----
        send_frame(0, 8'h81, 1'b0, 1'b0, 1'b0);
        repeat (200) @(negedge clk);
        check("frm_flag",  ferr0, 1);
        check("frm_empty", rx_empty0, 1);
        check("frm_done",  rxd_cnt0, 1);
        err_clr0 = 1'b1; @(negedge clk); err_clr0 = 1'b0;
        check("frm_clr", ferr0, 0);
        rx0 = 1'b0; repeat (16) @(negedge clk); rx0 = 1'b1;
        repeat (200) @(negedge clk);
        check("glitch_no_done", rxd_cnt0, 1);
        check("glitch_empty",   rx_empty0, 1);

        // ---- overrun on dut1 (depth 4) ----
        for (int w = 1; w <= 5; w++) send_frame(1, 8'(w), 1'b1, 1'b0, 1'b1);
        check("ovr_level", rx_level1, 4);
        check("ovr_flag",  ovr1, 1);
        check("ovr_perr",  perr1, 0);
        check("ovr_done",  rxd_cnt1, 7);
        for (int w = 1; w <= 4; w++) begin
            check($sformatf("ovr_pop%0d", w), rx_data1, w);
            pop_rx(1);
        end
        check("ovr_drained", {rx_empty1, rx_level1}, 4'b1000);

        // ---- echo mode on dut0 ----
        echo_en0 = 1'b1;
        fork
            send_frame(0, 8'h7E, 1'b0, 1'b0, 1'b1);
            get_tx_frame(2000, fr, found, waited);
            begin
                repeat (300) @(negedge clk);
                tx_data0 = 8'h11; tx_push0 = 1'b1;
                @(negedge clk);
                tx_push0 = 1'b0;
                check("echo_push_ignored", tx_level0, 0);
            end
        join
        check("echo_seen",  found, 1);
        check("echo_frame", fr, {1'b1, 8'h7E, 1'b0});
        repeat (200) @(negedge clk);
        check("echo_done_cnt", txd_cnt0, 3);
        check("echo_tx_idle",  {tx0, tx_busy0, tx_level0}, 7'b1000000);
        check("echo_rx_data",  rx_data0, 8'h7E);
        pop_rx(0);
        echo_en0 = 1'b0;

        // ---- reset mid-frame ----
        tx_data0 = 8'h00; tx_push0 = 1'b1; rx0 = 1'b0;
        @(negedge clk);
        tx_push0 = 1'b0;
        repeat (300) @(negedge clk);
        check("mid_busy", tx_busy0, 1);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_tx",    {tx0, tx_busy0, tx_done0}, 3'b100);
        check("mid_rst_level", tx_level0, 0);
        rx0 = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (1000) @(negedge clk);
        check("mid_rx_lost",   {rx_empty0, rx_level0}, 6'b100000);
        check("mid_rx_done",   rxd_cnt0, 2);
        check("mid_tx_idle",   tx0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_core_param.md
# uart_core_param

Parametrised UART controller: a tick generator, a TX engine and an RX engine, each buffered by its own FIFO, with configurable frame format and an optional echo (loopback) mode. It is the next generation of the team's 8N1 UART controller. It adds:
- popped RX data on a real output port
- parity and framing checks
- overrun detection
- FIFO fill levels
- a clean TX start path

It sits between the board `rx`/`tx` pins and the command/display logic.

## Interface
- `CLK_HZ`, 100_000_000, system clock frequency
- `BAUD`, 115_200, line rate
- `DATA_BITS`, 8, data bits per frame, legal range 5..8
- `PARITY`, 0, parity mode: 0 none, 1 odd, 2 even
- `STOP_BITS`, 1, stop bits, 1 or 2
- `FIFO_DEPTH`, 16, entries per FIFO, power of two ≥ 2
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  reset, asynchronous assert, active-low
- `rx`  in  1  serial input, asynchronous to `clk`
- `tx`  out  1  serial output, idle high
- `tx_push`  in  1  write `tx_data` into the TX FIFO
- `tx_data`  in  DATA_BITS  TX write data
- `tx_full`  out  1  TX FIFO full
- `tx_level`  out  $clog2(FIFO_DEPTH)+1  TX FIFO occupancy
- `tx_busy`  out  1  TX engine is sending a frame
- `tx_done`  out  1  one-cycle pulse at the end of the last stop bit
- `rx_pop`  in  1  consume the head of the RX FIFO
- `rx_data`  out  DATA_BITS  RX FIFO head (first-word fall-through)
- `rx_empty`  out  1  RX FIFO empty
- `rx_level`  out  $clog2(FIFO_DEPTH)+1  RX FIFO occupancy
- `rx_done`  out  1  one-cycle pulse when a frame completes
- `echo_en`  in  1  loopback: received words are queued for TX
- `err_clr`  in  1  clear all sticky error flags
- `rx_parity_err`, `rx_frame_err`, `rx_overrun`  out  1 each  sticky error flags

## Operation
- **Tick generator**
  - Free-running counter with divisor DIV = CLK_HZ/(BAUD*16), integer floor.
  - Produces a one-cycle `tick` at 16× the bit rate.
- **RX input**
  - `rx` passes through a 2-FF synchroniser whose flops reset to 1.
- **RX state machine:** IDLE→START→DATA→PARITY→STOP→IDLE.
  - IDLE: a low on the synchronised `rx` starts tick counting.
  - START: re-sample at tick 8. If high, return to IDLE (glitch reject). If low, it is the mid-bit reference.
  - DATA: sample every 16 ticks from the mid-bit reference, LSB first.
  - PARITY: present only when PARITY≠0.
  - STOP: sample once at mid-bit, even when STOP_BITS=2.
- **RX frame completion** (at STOP mid-bit):
  - Stop bit = 0: set `rx_frame_err`, discard the word, pulse `rx_done`.
  - Parity mismatch: set `rx_parity_err`, still push the word.
  - RX FIFO full at push time: drop the word and set `rx_overrun`.
- **Error flags**
  - Flags are sticky until `err_clr`.
  - Set and clear in the same cycle: set wins.
- **TX engine:** IDLE→START→DATA→PARITY→STOP→IDLE, 16 ticks per bit.
  - Loads from the TX FIFO when IDLE and the FIFO is non-empty.
  - Parity is XOR of the data bits, inverted for odd.
  - Sends STOP_BITS full stop bits.
  - `tx_done` pulses on the final tick of the last stop bit.
  - Back-to-back frames: no idle bit is inserted when the FIFO is non-empty.
- **Echo mode** (`echo_en` = 1):
  - Every word pushed into the RX FIFO is also pushed into the TX FIFO.
  - `tx_push` is ignored.
  - If the TX FIFO is full, the echo copy is dropped silently.
- **FIFO rules** (both FIFOs):
  - Push when full: ignored; contents unchanged.
  - Pop when empty: ignored.
  - Push and pop together when full: both take effect and the level is unchanged.
  - Push and pop together when empty: only the push takes effect.
  - Pointers wrap modulo FIFO_DEPTH.

## Timing
- **Reset values:**
  - `tx`=1; `tx_busy`=0; `tx_done`=0; `rx_done`=0.
  - `rx_empty`=1; `tx_full`=0; levels=0; `rx_data`=0.
  - All error flags 0; both state machines in IDLE; tick counter 0.
- **Reset mid-frame:** `tx` returns to 1 immediately (asynchronous) and any partial RX word is lost.
- **TX latency:** `tx_push` sampled at edge N → `tx_busy`=1 and `tx`=0 after edge N+2. The start bit lasts 16 ticks, measured from the first tick after load.
- **RX read:** `rx_data` is valid while `rx_empty`=0. `rx_pop` sampled at edge N → next word (or `rx_empty`=1) after edge N.
- **RX status update:** `rx_done`, the RX FIFO push and the error flags all update on the same edge.
- **Level outputs:** `tx_level` and `rx_level` are registered and update on the edge of the push or pop.

## Structure
- **Package `uart_pkg`:**
  - parity mode constants `PAR_NONE`/`PAR_ODD`/`PAR_EVEN`
  - state encodings for the TX and RX state machines
  - `OVERSAMPLE` = 16
- **Sub-module `uart_sync_fifo`:**
  - parameters WIDTH, DEPTH
  - ports: push, pop, din, dout (FWFT), full, empty, level
  - instantiated twice
- The tick generator, TX engine and RX engine stay inline in this module.

## Test plan
Defaults (DIV=54, 864 clocks per bit) unless stated.
- **Reset:** assert `rst`=0 mid-frame → `tx`=1 and all outputs at their reset values within the same cycle.
- **TX back-to-back:** push 0xA5 and 0x3C on consecutive cycles → line shows 0,10100101 (LSB first),1, then an immediate second frame; `tx_done` pulses twice; `tx_level` steps 2→1→0.
- **RX even parity:** PARITY=2, drive 0x55 with parity 0 → `rx_data`=0x55, no errors. Repeat with parity 1 → word stored and `rx_parity_err`=1 until `err_clr`.
- **RX error cases:**
  - stop bit 0 on 0x81 → `rx_frame_err`=1, `rx_empty` stays 1
  - 4-tick low glitch on `rx` → no `rx_done`
- **RX overrun:** FIFO_DEPTH=4, send 5 words with no pops → `rx_level`=4, `rx_overrun`=1, pops return words 1..4 in order.
- **Echo mode:** `echo_en`=1, receive 0x7E → same frame on `tx` about 1 frame later; a concurrent `tx_push` of 0x11 is not transmitted.
